// File: rtl/kb_uart_bridge.sv
// Keyboard-to-UART bridge: 2**ADDR_W deep character FIFO feeding a paced UART writer.
// Define KB_BRIDGE_CRLF_EN to expand each transmitted CR into CR,LF.
module kb_uart_bridge #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned OVF_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_char_valid,
  input  logic [DATA_W-1:0]    i_char,
  output logic                 o_char_rd,
  input  logic                 i_tx_full,
  output logic                 o_wr_uart,
  output logic [DATA_W-1:0]    o_wr_data,
  output logic [ADDR_W:0]      o_fifo_count,
  output logic                 o_overflow,
  output logic [OVF_CNT_W-1:0] o_ovf_count,
  input  logic                 i_clr_ovf
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FullCnt = (ADDR_W + 1)'(DEPTH);

`ifdef KB_BRIDGE_CRLF_EN
  localparam logic [DATA_W-1:0] CharCr = DATA_W'(8'h0D);
  localparam logic [DATA_W-1:0] CharLf = DATA_W'(8'h0A);
  typedef enum logic [1:0] {StIdle, StGap, StLf} state_e;
  logic lf_pend_q, lf_pend_d;
`else
  typedef enum logic [1:0] {StIdle, StGap} state_e;
`endif

  state_e state_q, state_d;

  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic [ADDR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]      count_q, count_d;
  logic                 push, pop, drop;
  logic [DATA_W-1:0]    head;
  logic                 wr_uart_q, wr_uart_d;
  logic [DATA_W-1:0]    wr_data_q, wr_data_d;
  logic                 overflow_q, overflow_d;
  logic [OVF_CNT_W-1:0] ovf_count_q, ovf_count_d;

  assign o_char_rd    = i_char_valid;
  assign o_wr_uart    = wr_uart_q;
  assign o_wr_data    = wr_data_q;
  assign o_fifo_count = count_q;
  assign o_overflow   = overflow_q;
  assign o_ovf_count  = ovf_count_q;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  always_comb begin
    pop  = (state_q == StIdle) && (count_q != '0) && !i_tx_full;
    push = i_char_valid && ((count_q != FullCnt) || pop);
    drop = i_char_valid && !push;
    head = mem_q[rd_ptr_q];
    unique case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wr_uart_d = 1'b0;
    wr_data_d = wr_data_q;
`ifdef KB_BRIDGE_CRLF_EN
    lf_pend_d = lf_pend_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          wr_uart_d = 1'b1;
          wr_data_d = head;
          state_d   = StGap;
`ifdef KB_BRIDGE_CRLF_EN
          lf_pend_d = (head == CharCr);
`endif
        end
      end
      StGap: begin
`ifdef KB_BRIDGE_CRLF_EN
        state_d = lf_pend_q ? StLf : StIdle;
`else
        state_d = StIdle;
`endif
      end
`ifdef KB_BRIDGE_CRLF_EN
      StLf: begin
        if (!i_tx_full) begin
          wr_uart_d = 1'b1;
          wr_data_d = CharLf;
          lf_pend_d = 1'b0;
          state_d   = StGap;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // A drop outranks a simultaneous clear so the lost character stays visible.
  always_comb begin
    overflow_d  = overflow_q;
    ovf_count_d = ovf_count_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (i_clr_ovf) begin
        ovf_count_d = OVF_CNT_W'(1);
      end else if (ovf_count_q != '1) begin
        ovf_count_d = ovf_count_q + OVF_CNT_W'(1);
      end
    end else if (i_clr_ovf) begin
      overflow_d  = 1'b0;
      ovf_count_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_char;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_uart_q   <= 1'b0;
      wr_data_q   <= '0;
      overflow_q  <= 1'b0;
      ovf_count_q <= '0;
`ifdef KB_BRIDGE_CRLF_EN
      lf_pend_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_uart_q   <= wr_uart_d;
      wr_data_q   <= wr_data_d;
      overflow_q  <= overflow_d;
      ovf_count_q <= ovf_count_d;
`ifdef KB_BRIDGE_CRLF_EN
      lf_pend_q   <= lf_pend_d;
`endif
      if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_kb_uart_bridge.sv
// Directed self-checking bench for kb_uart_bridge; CR expectations follow KB_BRIDGE_CRLF_EN.
module tb_kb_uart_bridge;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned OVF_CNT_W = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 char_valid = 1'b0;
  logic [DATA_W-1:0]    char_in = '0;
  logic                 char_rd;
  logic                 tx_full = 1'b0;
  logic                 wr_uart;
  logic [DATA_W-1:0]    wr_data;
  logic [ADDR_W:0]      fifo_count;
  logic                 overflow;
  logic [OVF_CNT_W-1:0] ovf_count;
  logic                 clr_ovf = 1'b0;

  always #5 clk = ~clk;

  kb_uart_bridge #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .OVF_CNT_W(OVF_CNT_W)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_char_valid(char_valid),
    .i_char      (char_in),
    .o_char_rd   (char_rd),
    .i_tx_full   (tx_full),
    .o_wr_uart   (wr_uart),
    .o_wr_data   (wr_data),
    .o_fifo_count(fifo_count),
    .o_overflow  (overflow),
    .o_ovf_count (ovf_count),
    .i_clr_ovf   (clr_ovf)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Capture every UART write; flag any write that follows a sampled tx_full.
  logic [7:0] outq[$];
  int         viol = 0;
  logic       last_full = 1'b0;

  always @(posedge clk) last_full <= tx_full;

  always @(negedge clk) begin
    if (wr_uart) begin
      outq.push_back(wr_data);
      if (last_full) viol++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
  endtask

  initial begin
    // Reset state, with a character offered during reset
    char_valid = 1'b1;
    char_in    = 8'h55;
    tick(2);
    check("rst_char_rd", 32'(char_rd), 32'd1);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_wr_uart", 32'(wr_uart), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_ovf", 32'(ovf_count), 32'd0);
    char_valid = 1'b0;
    rst_n = 1'b1;
    tick(3);
    check("post_rst_count", 32'(fifo_count), 32'd0);
    check("post_rst_nowr", 32'(outq.size()), 32'd0);

    // Single character latency
    char_valid = 1'b1;
    char_in    = 8'h41;
    tick(1);
    char_valid = 1'b0;
    check("lat_c1_count", 32'(fifo_count), 32'd1);
    check("lat_c1_wr", 32'(wr_uart), 32'd0);
    tick(1);
    check("lat_c2_wr", 32'(wr_uart), 32'd1);
    check("lat_c2_data", 32'(wr_data), 32'h41);
    check("lat_c2_count", 32'(fifo_count), 32'd0);
    tick(1);
    check("lat_c3_gap", 32'(wr_uart), 32'd0);
    tick(3);
    outq.delete();

    // Stalled fill with overflow, then ordered drain
    tx_full = 1'b1;
    tick(2);
    for (int i = 0; i < 20; i++) begin
      char_valid = 1'b1;
      char_in    = 8'(i);
      tick(1);
    end
    char_valid = 1'b0;
    check("fill_count", 32'(fifo_count), 32'd16);
    check("fill_ovf_cnt", 32'(ovf_count), 32'd4);
    check("fill_ovf", 32'(overflow), 32'd1);
    check("stall_nowr", 32'(outq.size()), 32'd0);
    tx_full = 1'b0;
    tick(40);
    check("drain_size", 32'(outq.size()), 32'd16);
    for (int i = 0; i < 16; i++) check($sformatf("drain[%0d]", i), 32'(outq[i]), 32'(i));
    check("drain_count", 32'(fifo_count), 32'd0);
    outq.delete();

    // Saturation, clear, and drop-beats-clear
    pulse_clr();
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_ovf_cnt", 32'(ovf_count), 32'd0);
    tx_full = 1'b1;
    tick(2);
    for (int i = 0; i < 300; i++) begin
      char_valid = 1'b1;
      char_in    = 8'(i);
      tick(1);
    end
    char_valid = 1'b0;
    check("sat_ovf_cnt", 32'(ovf_count), 32'hFF);
    check("sat_ovf", 32'(overflow), 32'd1);
    check("sat_count", 32'(fifo_count), 32'd16);
    pulse_clr();
    check("sat_clr_cnt", 32'(ovf_count), 32'd0);
    check("sat_clr_ovf", 32'(overflow), 32'd0);
    char_valid = 1'b1;
    char_in    = 8'hEE;
    clr_ovf    = 1'b1;
    tick(1);
    char_valid = 1'b0;
    clr_ovf    = 1'b0;
    check("dropclr_ovf", 32'(overflow), 32'd1);
    check("dropclr_cnt", 32'(ovf_count), 32'd1);
    pulse_clr();
    tx_full = 1'b0;
    tick(40);
    check("sat_drain_size", 32'(outq.size()), 32'd16);
    check("sat_drain_last", 32'(outq[15]), 32'h0F);
    outq.delete();

    // CR handling
    char_valid = 1'b1;
    char_in    = 8'h0D;
    tick(1);
    char_in    = 8'h42;
    tick(1);
    char_valid = 1'b0;
    tick(20);
`ifdef KB_BRIDGE_CRLF_EN
    check("crlf_size", 32'(outq.size()), 32'd3);
    check("crlf_0", 32'(outq[0]), 32'h0D);
    check("crlf_1", 32'(outq[1]), 32'h0A);
    check("crlf_2", 32'(outq[2]), 32'h42);
`else
    check("cr_size", 32'(outq.size()), 32'd2);
    check("cr_0", 32'(outq[0]), 32'h0D);
    check("cr_1", 32'(outq[1]), 32'h42);
`endif
    outq.delete();

    // Reset mid-operation with tx_full toggling every 3 cycles
    for (int i = 0; i < 28; i++) begin
      tx_full    = ((i / 3) % 2) == 1;
      char_valid = 1'b1;
      char_in    = 8'(8'h80 + i);
      if (i == 25) begin
        rst_n = 1'b0;
        #1;
        outq.delete();
        check("mid_rst_wr", 32'(wr_uart), 32'd0);
        check("mid_rst_data", 32'(wr_data), 32'd0);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_ovf_cnt", 32'(ovf_count), 32'd0);
        check("mid_rst_char_rd", 32'(char_rd), 32'd1);
      end
      tick(1);
    end
    char_valid = 1'b0;
    tx_full    = 1'b0;
    rst_n      = 1'b1;
    tick(10);
    check("post_rst_quiet", 32'(outq.size()), 32'd0);
    check("post_rst_empty", 32'(fifo_count), 32'd0);
    check("post_rst_ovf", 32'(ovf_count), 32'd0);
    for (int i = 28; i < 40; i++) begin
      char_valid = 1'b1;
      char_in    = 8'(8'h80 + i);
      tick(1);
    end
    char_valid = 1'b0;
    tick(40);
    check("resume_size", 32'(outq.size()), 32'd12);
    for (int k = 0; k < 12; k++) check($sformatf("resume[%0d]", k), 32'(outq[k]), 32'(8'h80 + 28 + k));

    check("no_wr_after_full", 32'(viol), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
